// File: rtl/rpi_out_pkg.sv
// -----------------------------------------------------------------------------
// rpi_out_pkg
//   Shared types and constants for the FPGA->RPi outbound entry arbiter.
//   - arb_state_t : arbiter FSM states (idle / address word / data word)
//   - TAG_ADDR / TAG_DATA : bit 8 of each 9-bit ring word
//   - RING_SLACK  : a grant needs at least this many free-or-reserved slots,
//                   i.e. two words for the pair plus the permanently empty slot
// -----------------------------------------------------------------------------
package rpi_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic TAG_ADDR   = 1'b1;
  localparam logic TAG_DATA   = 1'b0;
  localparam int   RING_SLACK = 3;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Scans the request mask starting at
//   last+1 and wrapping, so the previous winner has the lowest priority.
// Ports
//   req    in   NREQ    request mask
//   last   in   IDX_W   index of the previous winner
//   grant  out  NREQ    one-hot winner (all zero when no request)
//   idx    out  IDX_W   binary index of the winner
//   any    out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import rpi_out_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // cand_idx[k] is the requester examined at priority position k (0 = highest).
  logic [IDX_W-1:0] cand_idx [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    localparam int OFS = gi + 1;
    assign cand_idx[gi] = IDX_W'((int'(last) + OFS) % NREQ);
  end

  // Walk from lowest to highest priority so the highest-priority hit is the
  // last assignment and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant = NREQ'(1) << cand_idx[k];
        idx   = cand_idx[k];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpi_out_arbiter.sv
// -----------------------------------------------------------------------------
// rpi_out_arbiter
//   Shares the outbound FPGA->RPi entry ring among the ISA-port emulators
//   (IDE, GUS, OPL3, SB). Each granted event is written as an atomic pair:
//   {1,addr} then {0,data}. Also drives the transmit-pending flag.
// Optional build macro: RPI_OUT_ARB_STATS_EN adds stat_stall / stat_last.
// Ports
//   clk           in   1        system clock
//   rst_n         in   1        asynchronous active-low reset
//   req_valid     in   NREQ     event pending, held until req_ack
//   req_addr      in   NREQ*8   port low byte, slice i = [8i+7:8i]
//   req_data      in   NREQ*8   data byte, slice i = [8i+7:8i]
//   req_ack       out  NREQ     one-cycle pulse: event captured
//   o_rd_address  in   PTR_W    RPi read pointer (already in clk domain)
//   o_wr_address  out  PTR_W    ring write pointer
//   o_data        out  9        ring write word
//   o_wren        out  1        ring write strobe
//   tx_req        out  1        registered: write pointer != read pointer
//   stat_stall    out  16       (stats build) saturating stalled-IDLE count
//   stat_last     out  3        (stats build) index of most recent grant
// -----------------------------------------------------------------------------
module rpi_out_arbiter
  import rpi_out_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*8-1:0]   req_addr,
  input  logic [NREQ*8-1:0]   req_data,
  output logic [NREQ-1:0]     req_ack,
  input  logic [PTR_W-1:0]    o_rd_address,
  output logic [PTR_W-1:0]    o_wr_address,
  output logic [8:0]          o_data,
  output logic                o_wren,
  output logic                tx_req
`ifdef RPI_OUT_ARB_STATS_EN
  ,
  output logic [15:0]         stat_stall,
  output logic [2:0]          stat_last
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Largest fill level that still leaves room for a full pair plus the
  // always-empty slot: 2**PTR_W - RING_SLACK.
  localparam logic [PTR_W-1:0] USED_MAX = {PTR_W{1'b1}} - PTR_W'(RING_SLACK - 1);

  arb_state_t       state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [7:0]       lat_addr_reg, lat_data_reg;
  logic [NREQ-1:0]  grant_oh_reg;
  logic [IDX_W-1:0] last_grant_reg;
  logic             tx_req_reg;

  logic [PTR_W-1:0] used;
  logic             space_ok;
  logic             take;

  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [7:0]       addr_arr [NREQ];
  logic [7:0]       data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[8*gi +: 8];
    assign data_arr[gi] = req_data[8*gi +: 8];
  end

  // Modular distance; the read pointer can only ever free space, so checking
  // once in IDLE is enough for both words of the pair.
  assign used     = wr_ptr_reg - o_rd_address;
  assign space_ok = (used <= USED_MAX);

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    o_wren      = 1'b0;
    o_data      = '0;
    req_ack     = '0;
    take        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_any && space_ok) begin
          take       = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_wren      = 1'b1;
        o_data      = {TAG_ADDR, lat_addr_reg};
        req_ack     = grant_oh_reg;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        state_next  = ST_DATA;
      end
      ST_DATA: begin
        o_wren      = 1'b1;
        o_data      = {TAG_DATA, lat_data_reg};
        wr_ptr_next = wr_ptr_reg + 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      lat_addr_reg   <= '0;
      lat_data_reg   <= '0;
      grant_oh_reg   <= '0;
      last_grant_reg <= IDX_W'(NREQ - 1);
      tx_req_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      // Compare against the post-write pointer so tx_req tracks this cycle's write.
      tx_req_reg <= (wr_ptr_next != o_rd_address);
      if (take) begin
        lat_addr_reg   <= addr_arr[pick_idx];
        lat_data_reg   <= data_arr[pick_idx];
        grant_oh_reg   <= pick_grant;
        last_grant_reg <= pick_idx;
      end
    end
  end

  assign o_wr_address = wr_ptr_reg;
  assign tx_req       = tx_req_reg;

`ifdef RPI_OUT_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [2:0]  stat_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      stat_last_reg <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (|req_valid) && !space_ok &&
          (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (take) begin
        stat_last_reg <= 3'(pick_idx);
      end
    end
  end

  assign stat_stall = stall_cnt_reg;
  assign stat_last  = stat_last_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rpi_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rpi_out_arbiter
//   Directed bench for rpi_out_arbiter (NREQ=4, PTR_W=12). Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rpi_out_arbiter;

  localparam int NREQ  = 4;
  localparam int PTR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_addr = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic [PTR_W-1:0]  o_rd_address = '0;
  logic [PTR_W-1:0]  o_wr_address;
  logic [8:0]        o_data;
  logic              o_wren;
  logic              tx_req;
`ifdef RPI_OUT_ARB_STATS_EN
  logic [15:0]       stat_stall;
  logic [2:0]        stat_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpi_out_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .o_rd_address (o_rd_address),
    .o_wr_address (o_wr_address),
    .o_data       (o_data),
    .o_wren       (o_wren),
    .tx_req       (tx_req)
`ifdef RPI_OUT_ARB_STATS_EN
    ,
    .stat_stall   (stat_stall),
    .stat_last    (stat_last)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d);
    req_valid[i]       = 1'b1;
    req_addr[8*i +: 8] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    req_valid    = '0;
    o_rd_address = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for an ack, drops that requester's valid, returns its index.
  task automatic wait_ack(output int idx);
    idx = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ack[i]) begin
            idx          = i;
            req_valid[i] = 1'b0;
          end
        end
        $display("ack  req=%0d wr=%0d data=0x%03h", idx, o_wr_address, o_data);
        return;
      end
    end
  endtask

  logic [8:0]       wdata [16];
  logic [PTR_W-1:0] waddr [16];
  int               aord  [8];
  int               nw, na, idx, exp_w, bad, c;
  logic [15:0]      s0;

  initial begin
    // ---------------- reset values ----------------
    #2;
    check_val("rst_wren", 32'(o_wren), 32'd0);
    check_val("rst_data", 32'(o_data), 32'd0);
    check_val("rst_wr",   32'(o_wr_address), 32'd0);
    check_val("rst_ack",  32'(req_ack), 32'd0);
    check_val("rst_tx",   32'(tx_req), 32'd0);
    do_reset();

    // ---------------- single event ----------------
    set_req(0, 8'h70, 8'h01);
    @(negedge clk);
    $display("write wr=%0d data=0x%03h ack=%b", o_wr_address, o_data, req_ack);
    check_val("se_addr_wren", 32'(o_wren), 32'd1);
    check_val("se_addr_word", 32'(o_data), 32'h170);
    check_val("se_addr_ptr",  32'(o_wr_address), 32'd0);
    check_val("se_ack",       32'(req_ack), 32'b0001);
    req_valid[0] = 1'b0;
    @(negedge clk);
    $display("write wr=%0d data=0x%03h ack=%b", o_wr_address, o_data, req_ack);
    check_val("se_data_wren", 32'(o_wren), 32'd1);
    check_val("se_data_word", 32'(o_data), 32'h001);
    check_val("se_data_ptr",  32'(o_wr_address), 32'd1);
    check_val("se_ack_pulse", 32'(req_ack), 32'd0);
    check_val("se_tx",        32'(tx_req), 32'd1);
    @(negedge clk);
    check_val("se_idle_wren", 32'(o_wren), 32'd0);
    check_val("se_idle_ptr",  32'(o_wr_address), 32'd2);
    check_val("se_idle_tx",   32'(tx_req), 32'd1);
    o_rd_address = 12'd2;
    @(negedge clk);
    check_val("se_tx_clear",  32'(tx_req), 32'd0);

    // ---------------- four simultaneous requesters ----------------
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h40 + i), 8'(8'hA0 + i));
    nw = 0;
    na = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (o_wren) begin
        if (nw < 16) begin
          wdata[nw] = o_data;
          waddr[nw] = o_wr_address;
        end
        $display("write wr=%0d data=0x%03h", o_wr_address, o_data);
        nw++;
      end
      if (req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ack[i]) begin
            if (na < 8) aord[na] = i;
            na++;
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    check_val("rr_nwrites", 32'(nw), 32'd8);
    check_val("rr_nacks",   32'(na), 32'd4);
    for (int k = 0; k < 8; k++) begin
      exp_w = (k % 2 == 0) ? (32'h100 + 32'h40 + k / 2) : (32'hA0 + k / 2);
      if (k < nw) begin
        check_val($sformatf("rr_waddr%0d", k), 32'(waddr[k]), 32'(k));
        check_val($sformatf("rr_wdata%0d", k), 32'(wdata[k]), 32'(exp_w));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k < na) check_val($sformatf("rr_order%0d", k), 32'(aord[k]), 32'(k));
    end

    // Round-robin pointer: after winner 1, requesters 0 and 3 together -> 3 first.
    set_req(1, 8'h88, 8'h11);
    wait_ack(idx);
    check_val("rr_solo1", 32'(idx), 32'd1);
    set_req(0, 8'h89, 8'h12);
    set_req(3, 8'h8A, 8'h13);
    wait_ack(idx);
    check_val("rr_wrap_first", 32'(idx), 32'd3);
    wait_ack(idx);
    check_val("rr_wrap_second", 32'(idx), 32'd0);
`ifdef RPI_OUT_ARB_STATS_EN
    check_val("stat_last_0", 32'(stat_last), 32'd0);
`endif

    // ---------------- reset in the DATA state ----------------
    do_reset();
    set_req(2, 8'h33, 8'h44);
    wait_ack(idx);
    check_val("mr_ack", 32'(idx), 32'd2);
    @(negedge clk);
    check_val("mr_data_word", 32'(o_data), 32'h044);
    rst_n = 1'b0;
    #1;
    check_val("mr_wren", 32'(o_wren), 32'd0);
    check_val("mr_data", 32'(o_data), 32'd0);
    check_val("mr_ptr",  32'(o_wr_address), 32'd0);
    check_val("mr_tx",   32'(tx_req), 32'd0);
    check_val("mr_ack0", 32'(req_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 8'h11, 8'h22);
    wait_ack(idx);
    check_val("mr_regrant_idx",  32'(idx), 32'd1);
    check_val("mr_regrant_ptr",  32'(o_wr_address), 32'd0);
    check_val("mr_regrant_word", 32'(o_data), 32'h111);

    // ---------------- fill to the space limit, then wrap ----------------
    do_reset();
    set_req(0, 8'h88, 8'h55);   // held valid: re-granted every free IDLE
    c = 0;
    while (!(o_wr_address == 12'd4094 && !o_wren) && c < 7000) begin
      @(negedge clk);
      c++;
    end
    check_val("fill_reached", 32'(o_wr_address), 32'd4094);
`ifdef RPI_OUT_ARB_STATS_EN
    s0 = stat_stall;
    check_val("stall_start", 32'(s0), 32'd0);
`endif
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (o_wren || req_ack != '0) bad++;
    end
    check_val("full_no_grant", 32'(bad), 32'd0);
    check_val("full_ptr_hold", 32'(o_wr_address), 32'd4094);
`ifdef RPI_OUT_ARB_STATS_EN
    check_val("stall_five", 32'(stat_stall), 32'd5);
`endif
    o_rd_address = 12'd1;       // fill level now exactly one pair plus the gap
    @(negedge clk);
    check_val("wrap_addr_wren", 32'(o_wren), 32'd1);
    check_val("wrap_addr_ptr",  32'(o_wr_address), 32'd4094);
    check_val("wrap_addr_word", 32'(o_data), 32'h188);
    @(negedge clk);
    check_val("wrap_data_ptr",  32'(o_wr_address), 32'd4095);
    check_val("wrap_data_word", 32'(o_data), 32'h055);
    @(negedge clk);
    check_val("wrap_ptr_zero",  32'(o_wr_address), 32'd0);
    check_val("wrap_idle_wren", 32'(o_wren), 32'd0);
    check_val("wrap_tx",        32'(tx_req), 32'd1);
`ifdef RPI_OUT_ARB_STATS_EN
    check_val("stall_after_wrap", 32'(stat_stall), 32'd5);
    // Ring is full again (used=4095) with the request still held.
    repeat (65540) @(negedge clk);
    check_val("stall_saturate", 32'(stat_stall), 32'd65535);
    check_val("stat_last_fill", 32'(stat_last), 32'd0);
`endif
    req_valid = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
